// File: rtl/qspi_flash_pkg.sv
// Shared opcodes, state encoding and per-command mode decode for the QSPI flash model.
package qspi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_QUAD_OUT  = 8'h6B;
  localparam logic [7:0] CMD_QUAD_IO   = 8'hEB;
  localparam logic [7:0] CMD_JEDEC     = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } qspi_state_t;

  typedef struct packed {
    logic quad_addr;
    logic quad_data;
    logic dummy_en;
  } cmd_mode_t;

  function automatic cmd_mode_t cmd_mode(input logic [7:0] op);
    cmd_mode_t m;
    m = '0;
    case (op)
      CMD_FAST_READ: m.dummy_en = 1'b1;
      CMD_QUAD_OUT: begin
        m.dummy_en  = 1'b1;
        m.quad_data = 1'b1;
      end
      CMD_QUAD_IO: begin
        m.dummy_en  = 1'b1;
        m.quad_data = 1'b1;
        m.quad_addr = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/qspi_flash_model_if.sv
// Controller-side framing signals of the flash bus plus the model's status outputs.
// Protocol: a transaction is framed by cs low; sclk is mode-0 (idles low), data sampled on rise, shifted on fall.
interface qspi_flash_model_if;
  logic       cs;
  logic       sclk;
  logic [7:0] last_cmd;
  logic       cmd_error;

  modport master (output cs, output sclk, input last_cmd, input cmd_error);
  modport slave  (input cs, input sclk, output last_cmd, output cmd_error);
endinterface

// File: rtl/spi_edge_detect.sv
// Oversamples sclk on the system clock and produces single-clk rise/fall pulses.
module spi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sclk,
  output logic o_rise,
  output logic o_fall
);
  logic r_sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sclk_q <= 1'b0;
    else     r_sclk_q <= i_sclk;
  end

  assign o_rise = i_sclk & ~r_sclk_q;
  assign o_fall = ~i_sclk & r_sclk_q;
endmodule

// File: rtl/qspi_flash_model.sv
// QSPI NOR flash model: single/fast/quad reads and JEDEC ID served from a preloaded bit buffer.
module qspi_flash_model
  import qspi_flash_pkg::*;
#(
  parameter int          BUFFER_SIZE  = 1024,
  parameter int          ADDR_BYTES   = 3,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4016
) (
  input  logic                   clk,
  input  logic                   rst,
  qspi_flash_model_if.slave      bus,
  inout  wire                    si,
  inout  wire                    so,
  inout  wire                    wp,
  inout  wire                    hold,
  input  logic [BUFFER_SIZE-1:0] buffer,
  output qspi_state_t            o_dbg_state,
  output logic [3:0]             o_dbg_oe
);
  localparam int NBYTES = BUFFER_SIZE / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam logic [7:0]       ADDR_SINGLE_LAST = 8'(8 * ADDR_BYTES - 1);
  localparam logic [7:0]       ADDR_QUAD_LAST   = 8'(2 * ADDR_BYTES - 1);
  localparam logic [7:0]       DUMMY_LAST       = 8'(DUMMY_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST         = IDX_W'(NBYTES - 1);

  logic w_rise, w_fall;

  spi_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sclk (bus.sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  qspi_state_t       r_state;
  cmd_mode_t         r_mode;
  logic              r_jedec;
  logic [7:0]        r_cnt;
  logic [6:0]        r_sr;
  logic [7:0]        r_last_cmd;
  logic              r_cmd_error;
  logic [ADDR_W-1:0] r_addr;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_jcnt;
  logic [2:0]        r_bitpos;
  logic [3:0]        r_out;
  logic [3:0]        r_oe;

  logic [3:0]        w_io_in;
  logic [7:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_addr_mod;
  logic              w_addr_last;
  logic [7:0]        w_jedec_byte;
  logic [7:0]        w_byte;
  logic              w_byte_last;

  assign w_io_in     = {hold, wp, so, si};
  assign w_opcode    = {r_sr, w_io_in[0]};
  assign w_addr_next = r_mode.quad_addr ? ADDR_W'({r_addr, w_io_in})
                                        : ADDR_W'({r_addr, w_io_in[0]});
  // Out-of-range addresses fold back into the buffer instead of reading past it.
  assign w_addr_mod  = w_addr_next % ADDR_W'(NBYTES);
  assign w_addr_last = (r_cnt == (r_mode.quad_addr ? ADDR_QUAD_LAST : ADDR_SINGLE_LAST));

  always_comb begin
    w_jedec_byte = 8'hFF;
    case (r_jcnt)
      2'd0:    w_jedec_byte = JEDEC_ID[23:16];
      2'd1:    w_jedec_byte = JEDEC_ID[15:8];
      2'd2:    w_jedec_byte = JEDEC_ID[7:0];
      default: w_jedec_byte = 8'hFF;
    endcase
  end

  assign w_byte      = r_jedec ? w_jedec_byte : buffer[8*r_idx +: 8];
  assign w_byte_last = r_mode.quad_data ? (r_bitpos == 3'd1) : (r_bitpos == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_jedec     <= 1'b0;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_last_cmd  <= '0;
      r_cmd_error <= 1'b0;
      r_addr      <= '0;
      r_idx       <= '0;
      r_jcnt      <= '0;
      r_bitpos    <= '0;
      r_out       <= '0;
      r_oe        <= '0;
    end else if (bus.cs) begin
      // Deselect outranks any sclk edge seen in the same clk.
      r_state <= ST_IDLE;
      r_oe    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_CMD;
          r_mode   <= '0;
          r_jedec  <= 1'b0;
          r_cnt    <= '0;
          r_sr     <= '0;
          r_addr   <= '0;
          r_idx    <= '0;
          r_jcnt   <= '0;
          r_bitpos <= '0;
          r_out    <= '0;
        end
        ST_CMD: if (w_rise) begin
          r_sr  <= w_opcode[6:0];
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'd7) begin
            r_cnt      <= '0;
            r_last_cmd <= w_opcode;
            r_mode     <= cmd_mode(w_opcode);
            case (w_opcode)
              CMD_READ, CMD_FAST_READ, CMD_QUAD_OUT, CMD_QUAD_IO: r_state <= ST_ADDR;
              CMD_JEDEC: begin
                r_state <= ST_DATA;
                r_jedec <= 1'b1;
              end
              default: begin
                r_state     <= ST_IGNORE;
                r_cmd_error <= 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: if (w_rise) begin
          r_addr <= w_addr_next;
          r_cnt  <= r_cnt + 8'd1;
          if (w_addr_last) begin
            r_cnt   <= '0;
            r_idx   <= IDX_W'(w_addr_mod);
            r_state <= r_mode.dummy_en ? ST_DUMMY : ST_DATA;
          end
        end
        ST_DUMMY: if (w_rise) begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == DUMMY_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: if (w_fall) begin
          if (r_mode.quad_data) begin
            r_oe  <= 4'hF;
            r_out <= r_bitpos[0] ? w_byte[3:0] : w_byte[7:4];
          end else begin
            r_oe  <= 4'b0010;
            r_out <= {2'b00, w_byte[3'd7 - r_bitpos], 1'b0};
          end
          if (w_byte_last) begin
            r_bitpos <= '0;
            if (r_jedec) begin
              if (r_jcnt != 2'd3) r_jcnt <= r_jcnt + 2'd1;
            end else begin
              r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
          end else begin
            r_bitpos <= r_bitpos + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign si   = r_oe[0] ? r_out[0] : 1'bz;
  assign so   = r_oe[1] ? r_out[1] : 1'bz;
  assign wp   = r_oe[2] ? r_out[2] : 1'bz;
  assign hold = r_oe[3] ? r_out[3] : 1'bz;

  assign bus.last_cmd  = r_last_cmd;
  assign bus.cmd_error = r_cmd_error;
  assign o_dbg_state   = r_state;
  assign o_dbg_oe      = r_oe;
endmodule

// File: tb/tb_qspi_flash_model.sv
// Directed bench for qspi_flash_model: table of read transactions plus abort, bad-opcode and reset sequences.
module tb_qspi_flash_model;
  import qspi_flash_pkg::*;

  localparam int DUMMY = 8;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    bit          has_addr;
    bit          quad_addr;
    bit          has_dummy;
    bit          quad_data;
    int          nbytes;
    logic [31:0] exp_bytes;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_flash_model_if bus ();
  logic [3:0]  tb_io;
  logic [3:0]  tb_oe;
  wire         si, so, wp, hold;
  logic [63:0] buffer;
  qspi_state_t dbg_state;
  logic [3:0]  dbg_oe;

  assign si   = tb_oe[0] ? tb_io[0] : 1'bz;
  assign so   = tb_oe[1] ? tb_io[1] : 1'bz;
  assign wp   = tb_oe[2] ? tb_io[2] : 1'bz;
  assign hold = tb_oe[3] ? tb_io[3] : 1'bz;

  qspi_flash_model #(
    .BUFFER_SIZE  (64),
    .ADDR_BYTES   (3),
    .DUMMY_CYCLES (DUMMY),
    .JEDEC_ID     (24'hEF4016)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .si          (si),
    .so          (so),
    .wp          (wp),
    .hold        (hold),
    .buffer      (buffer),
    .o_dbg_state (dbg_state),
    .o_dbg_oe    (dbg_oe)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  vec_t vecs[8];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(output logic [3:0] pins, output logic [3:0] oe_seen);
    repeat (3) @(negedge clk);
    pins    = {hold, wp, so, si};
    oe_seen = dbg_oe;
    bus.sclk = 1'b1;
    repeat (3) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit quad, inout int zv);
    logic [3:0] p, o;
    for (int i = n - 1; i >= 0; i--) begin
      if (quad) begin
        tb_oe = 4'hF;
        tb_io = val[4*i +: 4];
      end else begin
        tb_oe = 4'b0001;
        tb_io = {3'b000, val[i]};
      end
      tick(p, o);
      if (o != 4'h0) zv++;
    end
  endtask

  task automatic read_byte(input bit quad, output logic [7:0] val, output int oe_bad);
    logic [3:0] p, o;
    val = 8'h00;
    oe_bad = 0;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      tick(p, o);
      if (quad) begin
        val = {val[3:0], p};
        if (o != 4'hF) oe_bad++;
      end else begin
        val = {val[6:0], p[1]};
        if (o != 4'b0010) oe_bad++;
      end
    end
  endtask

  task automatic begin_txn();
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_txn();
    repeat (3) @(negedge clk);
    bus.cs = 1'b1;
    tb_oe = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int zv, ob, obt;
    logic [3:0] p, o;
    logic [7:0] got;
    zv = 0;
    obt = 0;
    begin_txn();
    send_bits({24'h0, v.op}, 8, 1'b0, zv);
    if (v.has_addr) send_bits({8'h0, v.addr}, v.quad_addr ? 6 : 24, v.quad_addr, zv);
    tb_oe = 4'h0;
    if (v.has_dummy)
      for (int i = 0; i < DUMMY; i++) begin
        tick(p, o);
        if (o != 4'h0) zv++;
      end
    check_val($sformatf("v%0d pins Z before data", id), 32'(zv), 32'd0);
    for (int b = 0; b < v.nbytes; b++) exp_q.push_back(v.exp_bytes[8*(3-b) +: 8]);
    for (int b = 0; b < v.nbytes; b++) begin
      read_byte(v.quad_data, got, ob);
      obt += ob;
      check_val($sformatf("v%0d data byte %0d", id, b), 32'(got), 32'(exp_q.pop_front()));
    end
    check_val($sformatf("v%0d output enable during data", id), 32'(obt), 32'd0);
    end_txn();
    check_val($sformatf("v%0d oe after cs high", id), 32'(dbg_oe), 32'd0);
    check_val($sformatf("v%0d last_cmd", id), 32'(bus.last_cmd), 32'(v.op));
    check_val($sformatf("v%0d state idle", id), 32'(dbg_state), 32'(ST_IDLE));
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [23:0] addr, input bit ha,
                              input bit qa, input bit hd, input bit qd, input int n,
                              input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = addr; v.has_addr = ha; v.quad_addr = qa;
    v.has_dummy = hd; v.quad_data = qd; v.nbytes = n; v.exp_bytes = e;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t, required completion before it", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zv, ob;
    logic [3:0] p, o;
    logic [7:0] got;

    vecs[0] = mk(8'h03, 24'h000002, 1, 0, 0, 0, 3, 32'h22334400);
    vecs[1] = mk(8'h0B, 24'h000005, 1, 0, 1, 0, 1, 32'h55000000);
    vecs[2] = mk(8'hEB, 24'h000001, 1, 1, 1, 1, 2, 32'h11220000);
    vecs[3] = mk(8'h03, 24'h000007, 1, 0, 0, 0, 2, 32'h77000000);
    vecs[4] = mk(8'h9F, 24'h000000, 0, 0, 0, 0, 4, 32'hEF4016FF);
    vecs[5] = mk(8'h6B, 24'h000003, 1, 0, 1, 1, 2, 32'h33440000);
    vecs[6] = mk(8'h0B, 24'h00000E, 1, 0, 1, 0, 3, 32'h66770000);
    vecs[7] = mk(8'h03, 24'hFFFFFF, 1, 0, 0, 0, 2, 32'h77000000);

    buffer   = 64'h7766554433221100;
    rst      = 1'b1;
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    tb_oe    = 4'h0;
    tb_io    = 4'h0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("reset oe", 32'(dbg_oe), 32'd0);
    check_val("reset last_cmd", 32'(bus.last_cmd), 32'd0);
    check_val("reset cmd_error", 32'(bus.cmd_error), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    check_val("no cmd_error after valid cmds", 32'(bus.cmd_error), 32'd0);

    // cs abort mid-address, then a clean read from address 0
    zv = 0;
    begin_txn();
    send_bits(32'h03, 8, 1'b0, zv);
    send_bits(32'h00, 8, 1'b0, zv);
    end_txn();
    check_val("abort state idle", 32'(dbg_state), 32'(ST_IDLE));
    check_val("abort cmd_error", 32'(bus.cmd_error), 32'd0);
    run_vec(8, mk(8'h03, 24'h000000, 1, 0, 0, 0, 2, 32'h00110000));

    // cs rises on the same clk as the 8th command rise: the edge is dropped
    zv = 0;
    begin_txn();
    send_bits(32'h4F, 7, 1'b0, zv);
    tb_io = 4'h1;
    repeat (3) @(negedge clk);
    bus.cs   = 1'b1;
    bus.sclk = 1'b1;
    repeat (3) @(negedge clk);
    bus.sclk = 1'b0;
    tb_oe = 4'h0;
    repeat (3) @(negedge clk);
    check_val("cs/sclk race last_cmd", 32'(bus.last_cmd), 32'h03);
    check_val("cs/sclk race state", 32'(dbg_state), 32'(ST_IDLE));

    // unsupported opcode
    zv = 0;
    begin_txn();
    send_bits(32'h55, 8, 1'b0, zv);
    tb_oe = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(p, o);
      if (o != 4'h0) zv++;
    end
    check_val("bad opcode pins Z", 32'(zv), 32'd0);
    check_val("bad opcode state", 32'(dbg_state), 32'(ST_IGNORE));
    check_val("bad opcode cmd_error", 32'(bus.cmd_error), 32'd1);
    check_val("bad opcode last_cmd", 32'(bus.last_cmd), 32'h55);
    end_txn();
    check_val("cmd_error sticky", 32'(bus.cmd_error), 32'd1);

    // reset pulsed while data is being driven
    zv = 0;
    begin_txn();
    send_bits(32'h03, 8, 1'b0, zv);
    send_bits(32'h000000, 24, 1'b0, zv);
    tb_oe = 4'h0;
    read_byte(1'b0, got, ob);
    check_val("pre-reset data byte", 32'(got), 32'h00);
    check_val("pre-reset so driven", 32'(dbg_oe), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("async reset oe", 32'(dbg_oe), 32'd0);
    check_val("async reset cmd_error", 32'(bus.cmd_error), 32'd0);
    check_val("async reset last_cmd", 32'(bus.last_cmd), 32'd0);
    check_val("async reset state", 32'(dbg_state), 32'(ST_IDLE));
    bus.cs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qspi_flash_model.md
# qspi_flash_model

Parametrised, clock-synchronous QSPI NOR flash model; successor to `qspi_flash_buffer_mock`, used by core and `axi4lite_flash` benches. It answers single, fast and quad read commands plus JEDEC ID from a preloaded bit buffer, with configurable address width and dummy cycles. It oversamples the flash pins on the system clock, so the controller's `sclk` is treated as data.

## Interface
- `BUFFER_SIZE`, 1024: buffer width in bits; must be a multiple of 8.
- `ADDR_BYTES`, 3: address bytes per command (3 or 4).
- `DUMMY_CYCLES`, 8: dummy `sclk` cycles for 0x0B, 0x6B and 0xEB; must be ≥ 2.
- `JEDEC_ID`, 24'hEF4016: value returned by 0x9F.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `cs`, in, 1: chip select, active low.
- `sclk`, in, 1: flash clock; each level must last at least 2 `clk` periods.
- `si`, inout, 1: IO0.
- `so`, inout, 1: IO1.
- `wp`, inout, 1: IO2.
- `hold`, inout, 1: IO3.
- `buffer`, in, BUFFER_SIZE: memory contents; byte n is `buffer[8n+:8]`.
- `last_cmd`, out, 8: opcode of the most recent complete command byte.
- `cmd_error`, out, 1: sticky flag, set by any unsupported opcode.

## Operation
- Edge detection: `sclk_q` registers `sclk`. A rise is `sclk & !sclk_q`; a fall is `!sclk & sclk_q`.
- Sampling and driving: inputs are sampled on a rise. Outputs are updated on a fall. MSB first at every stage.
- Pin directions: IO pins are driven only when their output enable is set, otherwise they are Z. Single-bit data is driven on IO1. Quad nibbles map bit3..0 to IO3..IO0.
- State machine `IDLE → CMD → ADDR → DUMMY → DATA`, plus `IGNORE`.
- Transitions out of IDLE and CMD:
  - IDLE → CMD when `cs` is low.
  - CMD shifts 8 bits on IO0. Opcode handling:
    - 0x03: go to ADDR, single address, no dummy, single data.
    - 0x0B: go to ADDR, single address, DUMMY_CYCLES dummy, single data.
    - 0x6B: go to ADDR, single address, DUMMY_CYCLES dummy, quad data.
    - 0xEB: go to ADDR, quad address, DUMMY_CYCLES dummy (mode bits ignored), quad data.
    - 0x9F: go straight to DATA, streaming JEDEC_ID; after its 3 bytes, drive 0xFF.
    - Any other opcode: go to IGNORE and set `cmd_error`.
- Later states:
  - ADDR takes 8·ADDR_BYTES bits (single) or 2·ADDR_BYTES nibbles (quad).
  - DUMMY counts rises.
  - DATA streams bytes continuously. The address increments modulo BUFFER_SIZE/8, and the stored address is reduced modulo the buffer size, so out-of-range reads wrap.
- `cs` high at any time: all enables clear and the state returns to IDLE on the next `clk`. A partial command is discarded and `cmd_error` is not set.
- `wp` and `hold` are not interpreted as control signals.

## Timing
- Reset values: state IDLE, all output enables 0 (all IO pins Z), `last_cmd` 0, `cmd_error` 0, shift registers and counters 0.
- A rise or fall is acted on 1 `clk` after the `sclk` transition, through the `sclk_q` register.
- First data bit: driven on the first fall after the last address or dummy rise, and valid before the next rise.
- 0x03: first data bit follows the fall after the last address bit.
- `last_cmd` updates on the clk after the 8th command rise.
- Reset asserted mid-transfer: outputs go Z immediately and asynchronously.
- Simultaneous `cs` rise and `sclk` edge: `cs` wins and the edge is ignored.

## Structure
- Package `qspi_flash_pkg`:
  - opcode localparams `CMD_READ`, `CMD_FAST_READ`, `CMD_QUAD_OUT`, `CMD_QUAD_IO`, `CMD_JEDEC`;
  - state enum `qspi_state_t`;
  - per-command mode struct with fields quad address, quad data, dummy enable.
- Sub-module `spi_edge_detect`: `sclk` register and rise/fall pulses. Everything else stays in the top module.

## Test plan
Buffer bytes 0..7 = 00 11 22 33 44 55 66 77, with BUFFER_SIZE = 64.

1. 0x03, address 0x000002, 24 data clocks → IO1 streams 22 33 44, and `last_cmd` = 0x03.
2. 0x0B, address 0x000005, DUMMY_CYCLES = 8 → IO1 stays Z for exactly 8 dummy rises, then streams 55.
3. 0xEB, quad address 0x000001, 8 dummy cycles → IO3..0 carry nibbles 1,1,2,2 over 4 clocks.
4. 0x03, address 0x000007, 2 bytes → 77 then 00 (wrap).
5. 0x9F → EF 40 16, then FF.
6. Unknown opcode 0x55 → IO pins stay Z and `cmd_error` = 1. Then a `cs` abort mid-address on a 0x03 followed by a full 0x03 read of address 0 → 00 11. Then `rst` pulsed during data → all pins Z and `cmd_error` = 0.
